// File: rtl/inst_fetch_stage.sv
// inst_fetch_stage: owns the PC and fetches one word at a time from instruction
// memory over a req/ack handshake. It hands the word and its PC to decode, and
// accepts jump (active-low) and taken-branch redirects.
// Optional feature: define FETCH_ADEL_EN to report misaligned fetch addresses
// on id_adel. Without it, the PC is always kept word aligned.
module inst_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
  parameter logic [31:0] FLUSH_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ack,
  input  logic [31:0] inst_rdata,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  input  logic        id_ready,
  input  logic        jump_n,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        id_adel
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_KILL = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

`ifdef FETCH_ADEL_EN
  localparam logic [31:0] RESET_PC_EFF = RESET_PC;
`else
  localparam logic [31:0] RESET_PC_EFF = {RESET_PC[31:2], 2'b00};
`endif

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pend_pc;
  logic        r_inst_req;
  logic [31:0] r_inst_addr;
  logic        r_id_valid;
  logic [31:0] r_id_inst;
  logic [31:0] r_id_pc;

  logic        w_redirect;
  logic [31:0] w_target_raw;
  logic [31:0] w_target;
  logic [31:0] w_req_pc;
  logic        w_enter_req;
  logic        w_req_bad;

  assign w_redirect   = ~jump_n | branch_taken;
  assign w_target_raw = ~jump_n ? jump_target : branch_target;

`ifdef FETCH_ADEL_EN
  assign w_target  = w_target_raw;
  assign w_req_bad = |w_req_pc[1:0];
`else
  assign w_target  = w_target_raw & 32'hFFFF_FFFC;
  assign w_req_bad = 1'b0;
`endif

  // PC to issue on the next (re)entry into REQ, and whether we re-enter this cycle.
  // A redirect always carries the newest address, even on the KILL ack cycle.
  always_comb begin
    w_req_pc    = r_pc;
    w_enter_req = 1'b0;
    if (r_state != S_IDLE && w_redirect) w_req_pc = w_target;
    else if (r_state == S_KILL)          w_req_pc = r_pend_pc;
    case (r_state)
      S_IDLE:  w_enter_req = 1'b1;
      S_REQ:   w_enter_req = inst_ack & w_redirect;
      S_KILL:  w_enter_req = inst_ack;
      S_OUT:   w_enter_req = w_redirect | id_ready;
      default: w_enter_req = 1'b0;
    endcase
  end

  // Fetch FSM: issue, wait for ack, hold the word for decode, honour redirects.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC_EFF;
      r_pend_pc   <= RESET_PC_EFF;
      r_inst_req  <= 1'b0;
      r_inst_addr <= RESET_PC_EFF;
      r_id_valid  <= 1'b0;
      r_id_inst   <= FLUSH_INST;
      r_id_pc     <= 32'h0;
    end else if (w_enter_req) begin
      // A misaligned PC never reaches memory; it is reported to decode instead.
      r_pc        <= w_req_pc;
      r_inst_addr <= w_req_pc;
      r_inst_req  <= ~w_req_bad;
      r_id_valid  <= w_req_bad;
      r_id_inst   <= FLUSH_INST;
      r_state     <= w_req_bad ? S_OUT : S_REQ;
      if (w_req_bad) r_id_pc <= w_req_pc;
    end else begin
      case (r_state)
        S_REQ: begin
          if (inst_ack) begin
            r_id_inst  <= inst_rdata;
            r_id_pc    <= r_pc;
            r_id_valid <= 1'b1;
            r_pc       <= r_pc + 32'd4;
            r_inst_req <= 1'b0;
            r_state    <= S_OUT;
          end else if (w_redirect) begin
            // Request already on the bus: keep the address, remember where to go.
            r_pend_pc <= w_target;
            r_state   <= S_KILL;
          end
        end
        S_KILL: begin
          if (w_redirect) r_pend_pc <= w_target;
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_ADEL_EN
  logic r_id_adel;

  // Address-error flag follows the misaligned-PC report and drops on leaving OUT.
  always_ff @(posedge clk) begin
    if (!rst_n)           r_id_adel <= 1'b0;
    else if (w_enter_req) r_id_adel <= w_req_bad;
  end

  assign id_adel = r_id_adel;
`else
  assign id_adel = 1'b0;
`endif

  assign inst_req  = r_inst_req;
  assign inst_addr = r_inst_addr;
  assign id_valid  = r_id_valid;
  assign id_inst   = r_id_inst;
  assign id_pc     = r_id_pc;

endmodule
